// File: rtl/iir_inverse_if.sv
// Sample stream bundle for the IIR inverse filter: IIR output samples in,
// recovered samples plus error status out.
interface iir_inverse_if #(
  parameter int YW = 24
);
  logic signed [YW-1:0] y_data;
  logic                 data_en;
  logic                 sop;
  logic signed [7:0]    x_data;
  logic                 x_valid;
  logic                 x_err;
  logic [7:0]           err_cnt;

  modport master (
    output y_data, data_en, sop,
    input  x_data, x_valid, x_err, err_cnt
  );

  modport slave (
    input  y_data, data_en, sop,
    output x_data, x_valid, x_err, err_cnt
  );
endinterface

// File: rtl/iir_inverse.sv
// Inverse of y[n] = A*y[n-1] + B*x[n]: recovers x[n] = (y[n] - A*y[n-1]) / B
// through a 5-stage pipeline. Define IIR_INV_SAT_EN to saturate out-of-range x_data.
module iir_inverse #(
  parameter logic signed [7:0] A  = 8'sd3,
  parameter logic signed [7:0] B  = -8'sd4,
  parameter int                YW = 24
) (
  input logic           clk,
  input logic           rst_n,
  iir_inverse_if.slave  bus
);

  localparam int PW = 8 + YW;
  localparam int NW = 9 + YW;
  localparam logic signed [NW-1:0] B_EXT = NW'(B);
  localparam logic signed [NW-1:0] Q_MIN = NW'(-128);
  localparam logic signed [NW-1:0] Q_MAX = NW'(127);

  if (B == 8'sd0) begin : g_illegal_b
    $error("iir_inverse: B = 0 is not invertible");
  end
  if (YW < 16 || YW > 32) begin : g_illegal_yw
    $error("iir_inverse: YW must lie in 16..32");
  end

  // Stage valids, history and output registers (reset).
  logic                 v0_q, v0_d;
  logic                 v1_q, v1_d;
  logic                 v2_q, v2_d;
  logic                 v3_q, v3_d;
  logic signed [YW-1:0] hist_q, hist_d;
  logic signed [7:0]    x_data_q, x_data_d;
  logic                 x_valid_q, x_valid_d;
  logic                 x_err_q, x_err_d;
  logic [7:0]           err_cnt_q, err_cnt_d;

  // Stage data registers (no reset, qualified by the valids).
  logic signed [YW-1:0] y_cur_q, y_cur_d;
  logic signed [YW-1:0] y_prev_q, y_prev_d;
  logic signed [YW-1:0] yc1_q, yc1_d;
  logic signed [PW-1:0] p1_q, p1_d;
  logic signed [YW-1:0] yc2_q, yc2_d;
  logic signed [PW-1:0] p2_q, p2_d;
  logic signed [NW-1:0] num_q, num_d;

  // S4 combinational quotient/remainder and range check.
  logic signed [NW-1:0] q_full;
  logic signed [NW-1:0] r_full;
  logic                 q_lo;
  logic                 q_hi;
  logic                 s4_err;
  logic signed [7:0]    x_sel;

  // NOTE: every always_comb output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    v0_d     = bus.data_en;
    hist_d   = hist_q;
    y_cur_d  = y_cur_q;
    y_prev_d = y_prev_q;
    if (bus.data_en) begin
      y_cur_d  = bus.y_data;
      y_prev_d = bus.sop ? '0 : hist_q;
      hist_d   = bus.y_data;
    end
  end

  always_comb begin
    v1_d  = v0_q;
    yc1_d = yc1_q;
    p1_d  = p1_q;
    if (v0_q) begin
      yc1_d = y_cur_q;
      p1_d  = PW'(A) * PW'(y_prev_q);
    end
  end

  // Second product cycle only re-times the product; retiming can balance it.
  always_comb begin
    v2_d  = v1_q;
    yc2_d = yc2_q;
    p2_d  = p2_q;
    if (v1_q) begin
      yc2_d = yc1_q;
      p2_d  = p1_q;
    end
  end

  always_comb begin
    v3_d  = v2_q;
    num_d = num_q;
    if (v2_q) begin
      num_d = NW'(yc2_q) - NW'(p2_q);
    end
  end

  // SV division truncates toward zero; the remainder takes the dividend's sign.
  always_comb begin
    q_full = num_q / B_EXT;
    r_full = num_q % B_EXT;
    q_lo   = q_full < Q_MIN;
    q_hi   = q_full > Q_MAX;
    s4_err = (r_full != '0) | q_lo | q_hi;
`ifdef IIR_INV_SAT_EN
    if (q_hi) begin
      x_sel = 8'sh7F;
    end else if (q_lo) begin
      x_sel = 8'sh80;
    end else begin
      x_sel = q_full[7:0];
    end
`else
    x_sel = q_full[7:0];
`endif
  end

  always_comb begin
    x_valid_d = v3_q;
    x_err_d   = v3_q & s4_err;
    x_data_d  = v3_q ? x_sel : x_data_q;
    err_cnt_d = err_cnt_q;
    if (v3_q && s4_err && err_cnt_q != 8'hFF) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_q      <= 1'b0;
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      v3_q      <= 1'b0;
      hist_q    <= '0;
      x_data_q  <= '0;
      x_valid_q <= 1'b0;
      x_err_q   <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      v0_q      <= v0_d;
      v1_q      <= v1_d;
      v2_q      <= v2_d;
      v3_q      <= v3_d;
      hist_q    <= hist_d;
      x_data_q  <= x_data_d;
      x_valid_q <= x_valid_d;
      x_err_q   <= x_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // NOTE: pipeline data registers are left unreset; they are only observed
  // behind a valid bit, which is reset, so resetting them buys nothing.
  always_ff @(posedge clk) begin
    y_cur_q  <= y_cur_d;
    y_prev_q <= y_prev_d;
    yc1_q    <= yc1_d;
    p1_q     <= p1_d;
    yc2_q    <= yc2_d;
    p2_q     <= p2_d;
    num_q    <= num_d;
  end

  assign bus.x_data  = x_data_q;
  assign bus.x_valid = x_valid_q;
  assign bus.x_err   = x_err_q;
  assign bus.err_cnt = err_cnt_q;

endmodule

// File: doc/iir_inverse.md
# iir_inverse

Inverse (deconvolution) filter for the first-order IIR stage y[n] = A·y[n-1] + B·x[n]. It receives the IIR output stream and recovers x[n] = (y[n] − A·y[n-1]) / B. It sits at the far end of the filter link and checks that every recovered sample is exact and within 8-bit range. It is used in loopback verification of the IIR filter and to undo its shaping at the receive side.

## Interface
- A, 3, feedback coefficient, signed 8-bit constant.
- B, -4, input gain, signed 8-bit constant. B = 0 is illegal and must cause an elaboration error.
- YW, 24, input sample width, 16..32.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- y_data  in  YW  signed IIR output sample.
- data_en  in  1  y_data is valid this cycle. No backpressure.
- sop  in  1  start of stream, qualified by data_en. Treat y[n-1] as 0 for this sample.
- x_data  out  8  recovered signed sample.
- x_valid  out  1  x_data valid, one-cycle pulse per accepted sample.
- x_err  out  1  with x_valid: remainder ≠ 0 or quotient outside [-128,127].
- err_cnt  out  8  count of x_err pulses, saturates at 255.

## Operation
- Pipeline stages; each has a valid bit that moves with its data:
  - S0: capture y_data into y_cur and y_prev_sel. y_prev_sel is 0 if sop, else the history register.
  - S1/S2: two-cycle product p = A·y_prev_sel, (8+YW) bits, signed.
  - S3: num = y_cur − p, (9+YW) bits, no overflow possible.
  - S4: q = num / B (truncate toward zero) and r = num % B. Then run the range check and drive the output registers.
- History register: loads y_data on every accepted sample, including a sop sample. It holds its value while data_en is low, so gaps do not disturb y[n-1]. Reset value 0.
- x_err = (r ≠ 0) | (q < -128) | (q > 127).
- x_data = q[7:0] (wraps), unless saturation is built in (see Configuration).
- err_cnt increments on each x_valid & x_err. It holds at 255.
- Stages not carrying valid data hold their data registers. Only the valid bits clear.

## Timing
- Reset values: x_data 0, x_valid 0, x_err 0, err_cnt 0, history 0, all stage valids 0.
- Latency: a sample accepted at rising edge k produces x_valid high after edge k+4, for one cycle.
- Throughput: one sample per cycle. Output spacing equals input spacing, bubbles included.
- Back-to-back samples: each sample uses the history value loaded by the immediately preceding accepted sample.
- sop with data_en low is ignored.
- rst_n asserted mid-stream: in-flight samples are discarded immediately (asynchronous), with no x_valid produced for them. Recovery starts with the first data_en after rst_n deasserts, using history 0.
- x_err is meaningful only while x_valid = 1, and is 0 otherwise.

## Configuration
- IIR_INV_SAT_EN defined: out-of-range q saturates x_data to -128 or 127. x_err is still asserted.
- IIR_INV_SAT_EN undefined: x_data = q[7:0], two's-complement wrap. x_err is still asserted.
- Remainder detection and err_cnt behave the same in both builds.

## Test plan
All tests use A=3, B=-4, YW=24.
- Clean stream: sop+y=-4, then -20, then -56 on consecutive cycles → x_data 1, 2, -1 at edges k+4, k+5, k+6; x_err 0; err_cnt 0.
- Bubbles: sop+y=-4, three idle cycles, then y=-20 → x_data 1, three idle cycles, then x_data 2. History is held across the gap.
- Inexact: sop+y=-3 → x_data 0, x_err 1, err_cnt 1.
- Range: sop+y=1000 (q=-250) → x_err 1. x_data = -128 with IIR_INV_SAT_EN, 6 without it.
- sop restart: after the clean stream, sop+y=-4 → x_data 1, ignoring the prior history of -56.
- Reset mid-flight: three samples sent, rst_n pulsed low 2 cycles after the first → no x_valid from them, all outputs at reset values. Then y=-4 → x_data 1 four edges later.
